multicycle_control: RTL and testbench

// - Multicycle MIPS control FSM; the driving end of the ALU: issues alu_operation, selects ALU operands, consumes zero.
// - Sequences FETCH/DECODE/EXEC/MEM/WB, one instruction at a time.
// - Sits between the IR (opcode/funct) and the datapath muxes, register file and memory enables.

---
 rtl/mips_pkg.sv | 72 +++++++
 rtl/alu_op_decoder.sv | 26 ++
 rtl/multicycle_control.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control path: ALU op codes,
// opcode/funct encodings, operand-B select codes and the FSM state enum.
package mips_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned SRC_B_W  = 3;
  localparam int unsigned PC_SRC_W = 2;
  localparam int unsigned CNT_W    = 3;

  // ALU operation codes
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_LUI = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd8;

  // Opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [OP_W-1:0] F_SLL  = 6'h00;
  localparam logic [OP_W-1:0] F_SRL  = 6'h02;
  localparam logic [OP_W-1:0] F_ADD  = 6'h20;
  localparam logic [OP_W-1:0] F_ADDU = 6'h21;
  localparam logic [OP_W-1:0] F_SUB  = 6'h22;
  localparam logic [OP_W-1:0] F_SUBU = 6'h23;
  localparam logic [OP_W-1:0] F_AND  = 6'h24;
  localparam logic [OP_W-1:0] F_OR   = 6'h25;
  localparam logic [OP_W-1:0] F_NOR  = 6'h27;

  // ALU operand-B select
  localparam logic [SRC_B_W-1:0] SRC_B_REG   = 3'd0;
  localparam logic [SRC_B_W-1:0] SRC_B_FOUR  = 3'd1;
  localparam logic [SRC_B_W-1:0] SRC_B_SEXT  = 3'd2;
  localparam logic [SRC_B_W-1:0] SRC_B_SEXT2 = 3'd3;
  localparam logic [SRC_B_W-1:0] SRC_B_ZEXT  = 3'd4;

  // PC source select
  localparam logic [PC_SRC_W-1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [PC_SRC_W-1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [PC_SRC_W-1:0] PC_SRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_R_EXEC    = 4'd2,
    S_R_WB      = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_READ  = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_MEM_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_IMM_EXEC  = 4'd9,
    S_IMM_WB    = 4'd10,
    S_JUMP      = 4'd11
  } state_e;

endpackage

// File: rtl/alu_op_decoder.sv
// R-type funct to ALU operation decode, with a flag for supported functs.
module alu_op_decoder
  import mips_pkg::*;
(
  input  logic [OP_W-1:0]     funct,
  output logic [ALU_OP_W-1:0] alu_operation,
  output logic                funct_valid
);

  // Map funct to ALU op; anything unlisted is flagged invalid
  always_comb begin
    alu_operation = ALU_SLL;
    funct_valid   = 1'b1;
    case (funct)
      F_ADD, F_ADDU: alu_operation = ALU_ADD;
      F_SUB, F_SUBU: alu_operation = ALU_SUB;
      F_AND:         alu_operation = ALU_AND;
      F_OR:          alu_operation = ALU_OR;
      F_NOR:         alu_operation = ALU_NOR;
      F_SLL:         alu_operation = ALU_SLL;
      F_SRL:         alu_operation = ALU_SRL;
      default:       funct_valid   = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// memory wait counter. Outputs are a Moore decode of state, except pc_en in
// BRANCH which follows zero directly. All outputs are held 0 during reset.
// Optional feature macro: IMM_LOGIC_EN adds ANDI/ORI/LUI via IMM_EXEC.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     opcode,
  input  logic [OP_W-1:0]     funct,
  input  logic                zero,
  output logic [ALU_OP_W-1:0] alu_operation,
  output logic                alu_src_a,
  output logic [SRC_B_W-1:0]  alu_src_b,
  output logic                pc_en,
  output logic [PC_SRC_W-1:0] pc_source,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                illegal_op
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ALU_OP_W-1:0] r_alu_op;
  logic             funct_valid;
  logic             mem_last;

  alu_op_decoder u_alu_op_decoder (
    .funct         (funct),
    .alu_operation (r_alu_op),
    .funct_valid   (funct_valid)
  );

  assign mem_last = (cnt_q == CNT_W'(MEM_WAIT));

  // State and wait-counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_operation = ALU_SLL;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    pc_en         = 1'b0;
    pc_source     = PC_SRC_ALU;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_op    = 1'b0;

    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_last) begin
            ir_write      = 1'b1;
            pc_en         = 1'b1;
            alu_src_b     = SRC_B_FOUR;
            alu_operation = ALU_ADD;
            cnt_d         = '0;
            state_d       = S_DECODE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_DECODE: begin
          alu_src_b     = SRC_B_SEXT2;
          alu_operation = ALU_ADD;
          case (opcode)
            OP_RTYPE: begin
              if (funct_valid) begin
                state_d = S_R_EXEC;
              end else begin
                illegal_op = 1'b1;
                state_d    = S_FETCH;
              end
            end
            OP_LW, OP_SW:      state_d = S_MEM_ADDR;
            OP_BEQ, OP_BNE:    state_d = S_BRANCH;
            OP_ADDI, OP_ADDIU: state_d = S_IMM_EXEC;
`ifdef IMM_LOGIC_EN
            OP_ANDI, OP_ORI, OP_LUI: state_d = S_IMM_EXEC;
`endif
            OP_J:              state_d = S_JUMP;
            default: begin
              illegal_op = 1'b1;
              state_d    = S_FETCH;
            end
          endcase
        end

        S_R_EXEC: begin
          alu_src_a     = 1'b1;
          alu_src_b     = SRC_B_REG;
          alu_operation = r_alu_op;
          state_d       = S_R_WB;
        end

        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          state_d   = S_FETCH;
        end

        S_MEM_ADDR: begin
          alu_src_a     = 1'b1;
          alu_src_b     = SRC_B_SEXT;
          alu_operation = ALU_ADD;
          state_d       = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        end

        S_MEM_READ: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          if (mem_last) begin
            cnt_d   = '0;
            state_d = S_MEM_WB;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_MEM_WRITE: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          if (mem_last) begin
            cnt_d   = '0;
            state_d = S_FETCH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          state_d    = S_FETCH;
        end

        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_src_b     = SRC_B_REG;
          alu_operation = ALU_SUB;
          pc_source     = PC_SRC_ALUOUT;
          pc_en         = (opcode == OP_BEQ) ? zero : ~zero;
          state_d       = S_FETCH;
        end

        S_IMM_EXEC: begin
          alu_src_a     = 1'b1;
          alu_src_b     = SRC_B_SEXT;
          alu_operation = ALU_ADD;
`ifdef IMM_LOGIC_EN
          case (opcode)
            OP_ANDI: begin
              alu_src_b     = SRC_B_ZEXT;
              alu_operation = ALU_AND;
            end
            OP_ORI: begin
              alu_src_b     = SRC_B_ZEXT;
              alu_operation = ALU_OR;
            end
            OP_LUI: begin
              alu_src_b     = SRC_B_ZEXT;
              alu_operation = ALU_LUI;
            end
            default: ;
          endcase
`endif
          state_d = S_IMM_WB;
        end

        S_IMM_WB: begin
          reg_write = 1'b1;
          state_d   = S_FETCH;
        end

        S_JUMP: begin
          pc_source = PC_SRC_JUMP;
          pc_en     = 1'b1;
          state_d   = S_FETCH;
        end

        default: begin
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control: one instance at MEM_WAIT=0 and
// one at MEM_WAIT=2, each driven from its own per-cycle vector records.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] alu;
    logic       sa;
    logic [2:0] sb;
    logic       pe;
    logic [1:0] ps;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic       ill;
  } out_t;

  typedef struct {
    bit         sel;
    bit         rst;
    logic [5:0] op;
    logic [5:0] fn;
    bit         z;
    out_t       exp;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b1, rst1 = 1'b1;
  logic [5:0] op0 = '0, fn0 = '0, op1 = '0, fn1 = '0;
  logic       z0 = 1'b0, z1 = 1'b0;

  logic [3:0] alu0, alu1;
  logic       sa0, sa1, pe0, pe1, iord0, iord1, mr0, mr1, mw0, mw1;
  logic       irw0, irw1, rw0, rw1, rd0, rd1, m2r0, m2r1, ill0, ill1;
  logic [2:0] sb0, sb1;
  logic [1:0] ps0, ps1;

  multicycle_control #(.MEM_WAIT(0)) u_dut0 (
    .clk(clk), .reset(rst0), .opcode(op0), .funct(fn0), .zero(z0),
    .alu_operation(alu0), .alu_src_a(sa0), .alu_src_b(sb0), .pc_en(pe0),
    .pc_source(ps0), .iord(iord0), .mem_read(mr0), .mem_write(mw0),
    .ir_write(irw0), .reg_write(rw0), .reg_dst(rd0), .mem_to_reg(m2r0),
    .illegal_op(ill0)
  );

  multicycle_control #(.MEM_WAIT(2)) u_dut1 (
    .clk(clk), .reset(rst1), .opcode(op1), .funct(fn1), .zero(z1),
    .alu_operation(alu1), .alu_src_a(sa1), .alu_src_b(sb1), .pc_en(pe1),
    .pc_source(ps1), .iord(iord1), .mem_read(mr1), .mem_write(mw1),
    .ir_write(irw1), .reg_write(rw1), .reg_dst(rd1), .mem_to_reg(m2r1),
    .illegal_op(ill1)
  );

  out_t act0, act1;
  assign act0 = {alu0, sa0, sb0, pe0, ps0, iord0, mr0, mw0, irw0, rw0, rd0, m2r0, ill0};
  assign act1 = {alu1, sa1, sb1, pe1, ps1, iord1, mr1, mw1, irw1, rw1, rd1, m2r1, ill1};

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic out_t mk(input logic [3:0] alu, input logic sa, input logic [2:0] sb,
                              input logic pe, input logic [1:0] ps, input logic iord,
                              input logic mr, input logic mw, input logic irw,
                              input logic rw, input logic rd, input logic m2r,
                              input logic ill);
    mk = {alu, sa, sb, pe, ps, iord, mr, mw, irw, rw, rd, m2r, ill};
  endfunction

  // Hand-written expected output sets, one per FSM situation
  out_t e_zero, e_fetch_w, e_fetch, e_dec, e_ill, e_rwb, e_maddr, e_mr, e_mw;
  out_t e_mwb, e_imm, e_iwb, e_j;

  function automatic out_t e_rexec(input logic [3:0] alu);
    e_rexec = mk(alu, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic out_t e_br(input logic pe);
    e_br = mk(4'd4, 1, 3'd0, pe, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic add(input bit sel, input bit rst, input logic [5:0] op,
                     input logic [5:0] fn, input bit z, input out_t exp,
                     input string name);
    vec_t v;
    v.sel = sel; v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic add_r(input logic [5:0] fn, input logic [3:0] alu, input string name);
    add(0, 0, 6'h00, fn, 0, e_fetch, {name, "_fetch"});
    add(0, 0, 6'h00, fn, 0, e_dec,   {name, "_decode"});
    add(0, 0, 6'h00, fn, 0, e_rexec(alu), {name, "_rexec"});
    add(0, 0, 6'h00, fn, 0, e_rwb,   {name, "_rwb"});
  endtask

  task automatic add_br(input logic [5:0] op, input bit z, input bit pe, input string name);
    add(0, 0, op, 6'h00, z, e_fetch, {name, "_fetch"});
    add(0, 0, op, 6'h00, z, e_dec,   {name, "_decode"});
    add(0, 0, op, 6'h00, z, e_br(pe), {name, "_branch"});
  endtask

  initial begin
    e_zero    = '0;
    e_fetch_w = mk(4'd0, 0, 3'd0, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0);
    e_fetch   = mk(4'd3, 0, 3'd1, 1, 2'd0, 0, 1, 0, 1, 0, 0, 0, 0);
    e_dec     = mk(4'd3, 0, 3'd3, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_ill     = mk(4'd3, 0, 3'd3, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1);
    e_rwb     = mk(4'd0, 0, 3'd0, 0, 2'd0, 0, 0, 0, 0, 1, 1, 0, 0);
    e_maddr   = mk(4'd3, 1, 3'd2, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_mr      = mk(4'd0, 0, 3'd0, 0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0);
    e_mw      = mk(4'd0, 0, 3'd0, 0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 0);
    e_mwb     = mk(4'd0, 0, 3'd0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0);
    e_imm     = mk(4'd3, 1, 3'd2, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_iwb     = mk(4'd0, 0, 3'd0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0);
    e_j       = mk(4'd0, 0, 3'd0, 1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0);

    // MEM_WAIT=0 instance
    add(0, 1, 6'h00, 6'h20, 0, e_zero, "rst0_a");
    add(0, 1, 6'h00, 6'h20, 0, e_zero, "rst0_b");
    add_r(6'h20, 4'd3, "add");
    add_r(6'h22, 4'd4, "sub");
    add_r(6'h24, 4'd5, "and");
    add_r(6'h25, 4'd8, "or");
    add_r(6'h27, 4'd7, "nor");
    add_r(6'h00, 4'd0, "sll");
    add_r(6'h02, 4'd1, "srl");
    add_br(6'h04, 1, 1, "beq_z1");
    add_br(6'h04, 0, 0, "beq_z0");
    add_br(6'h05, 1, 0, "bne_z1");
    add_br(6'h05, 0, 1, "bne_z0");
    add(0, 0, 6'h2B, 6'h00, 0, e_fetch, "sw_fetch");
    add(0, 0, 6'h2B, 6'h00, 0, e_dec,   "sw_decode");
    add(0, 0, 6'h2B, 6'h00, 0, e_maddr, "sw_maddr");
    add(0, 0, 6'h2B, 6'h00, 0, e_mw,    "sw_mwrite");
    add(0, 0, 6'h23, 6'h00, 0, e_fetch, "lw_fetch");
    add(0, 0, 6'h23, 6'h00, 0, e_dec,   "lw_decode");
    add(0, 0, 6'h23, 6'h00, 0, e_maddr, "lw_maddr");
    add(0, 0, 6'h23, 6'h00, 0, e_mr,    "lw_mread");
    add(0, 0, 6'h23, 6'h00, 0, e_mwb,   "lw_mwb");
    add(0, 0, 6'h08, 6'h00, 0, e_fetch, "addi_fetch");
    add(0, 0, 6'h08, 6'h00, 0, e_dec,   "addi_decode");
    add(0, 0, 6'h08, 6'h00, 0, e_imm,   "addi_exec");
    add(0, 0, 6'h08, 6'h00, 0, e_iwb,   "addi_wb");
    add(0, 0, 6'h02, 6'h00, 0, e_fetch, "j_fetch");
    add(0, 0, 6'h02, 6'h00, 0, e_dec,   "j_decode");
    add(0, 0, 6'h02, 6'h00, 0, e_j,     "j_jump");
    add(0, 0, 6'h3F, 6'h00, 0, e_fetch, "op3f_fetch");
    add(0, 0, 6'h3F, 6'h00, 0, e_ill,   "op3f_illegal");
    add(0, 0, 6'h00, 6'h2A, 0, e_fetch, "fn2a_fetch");
    add(0, 0, 6'h00, 6'h2A, 0, e_ill,   "fn2a_illegal");
    add(0, 0, 6'h0D, 6'h00, 0, e_fetch, "ori_fetch");
`ifdef IMM_LOGIC_EN
    add(0, 0, 6'h0D, 6'h00, 0, e_dec,   "ori_decode");
    add(0, 0, 6'h0D, 6'h00, 0, mk(4'd8, 1, 3'd4, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0), "ori_exec");
    add(0, 0, 6'h0D, 6'h00, 0, e_iwb,   "ori_wb");
    add(0, 0, 6'h0F, 6'h00, 0, e_fetch, "lui_fetch");
    add(0, 0, 6'h0F, 6'h00, 0, e_dec,   "lui_decode");
    add(0, 0, 6'h0F, 6'h00, 0, mk(4'd2, 1, 3'd4, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0), "lui_exec");
    add(0, 0, 6'h0F, 6'h00, 0, e_iwb,   "lui_wb");
`else
    add(0, 0, 6'h0D, 6'h00, 0, e_ill,   "ori_illegal");
    add(0, 0, 6'h0F, 6'h00, 0, e_fetch, "lui_fetch");
    add(0, 0, 6'h0F, 6'h00, 0, e_ill,   "lui_illegal");
`endif
    add(0, 0, 6'h02, 6'h00, 0, e_fetch, "tail_fetch");

    // MEM_WAIT=2 instance: stretched LW, then reset in the middle of MEM_WRITE
    add(1, 1, 6'h23, 6'h00, 0, e_zero,    "rst1");
    add(1, 0, 6'h23, 6'h00, 0, e_fetch_w, "lw2_fetch1");
    add(1, 0, 6'h23, 6'h00, 0, e_fetch_w, "lw2_fetch2");
    add(1, 0, 6'h23, 6'h00, 0, e_fetch,   "lw2_fetch3");
    add(1, 0, 6'h23, 6'h00, 0, e_dec,     "lw2_decode");
    add(1, 0, 6'h23, 6'h00, 0, e_maddr,   "lw2_maddr");
    add(1, 0, 6'h23, 6'h00, 0, e_mr,      "lw2_mread1");
    add(1, 0, 6'h23, 6'h00, 0, e_mr,      "lw2_mread2");
    add(1, 0, 6'h23, 6'h00, 0, e_mr,      "lw2_mread3");
    add(1, 0, 6'h23, 6'h00, 0, e_mwb,     "lw2_mwb");
    add(1, 0, 6'h2B, 6'h00, 0, e_fetch_w, "sw2_fetch1");
    add(1, 0, 6'h2B, 6'h00, 0, e_fetch_w, "sw2_fetch2");
    add(1, 0, 6'h2B, 6'h00, 0, e_fetch,   "sw2_fetch3");
    add(1, 0, 6'h2B, 6'h00, 0, e_dec,     "sw2_decode");
    add(1, 0, 6'h2B, 6'h00, 0, e_maddr,   "sw2_maddr");
    add(1, 0, 6'h2B, 6'h00, 0, e_mw,      "sw2_mwrite1");
    add(1, 1, 6'h2B, 6'h00, 0, e_zero,    "sw2_rst_in_mwrite");
    add(1, 0, 6'h02, 6'h00, 0, e_fetch_w, "post_rst_fetch1");
    add(1, 0, 6'h02, 6'h00, 0, e_fetch_w, "post_rst_fetch2");
    add(1, 0, 6'h02, 6'h00, 0, e_fetch,   "post_rst_fetch3");
    add(1, 0, 6'h02, 6'h00, 0, e_dec,     "post_rst_decode");
    add(1, 0, 6'h02, 6'h00, 0, e_j,       "post_rst_jump");
    add(1, 0, 6'h02, 6'h00, 0, e_fetch_w, "post_j_fetch1");

    // Apply each record just after a rising edge and check before the next
    foreach (vecs[i]) begin
      out_t act;
      @(posedge clk);
      #1;
      if (vecs[i].sel == 1'b0) begin
        rst0 = vecs[i].rst; op0 = vecs[i].op; fn0 = vecs[i].fn; z0 = vecs[i].z;
      end else begin
        rst1 = vecs[i].rst; op1 = vecs[i].op; fn1 = vecs[i].fn; z1 = vecs[i].z;
      end
      @(negedge clk);
      act = (vecs[i].sel == 1'b0) ? act0 : act1;
      n_checks++;
      if (vecs[i].rst) begin
        if (act !== e_zero) begin
          n_fail++;
          $display("FAIL %s: reset state got %05h required all-zero", vecs[i].name, act);
        end
      end else begin
        if (act !== vecs[i].exp) begin
          n_fail++;
          $display("FAIL %s: got %05h required %05h", vecs[i].name, act, vecs[i].exp);
        end
      end
    end

    // Expired-wait check: MEM_WAIT=2 FETCH completes on its third cycle
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (!(irw1 === 1'b1 && pe1 === 1'b1 && mr1 === 1'b1 && alu1 === 4'd3)) begin
      n_fail++;
      $display("FAIL expired_wait: ir_write=%b pc_en=%b mem_read=%b alu=%0d", irw1, pe1, mr1, alu1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
